// File: rtl/mem_arb_pkg.sv
// Shared state encodings, operation type and sizing helpers for the line-transfer arbiter.
package mem_arb_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  localparam int WORD_W = 32;

  function automatic int line_size(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

  // Width able to hold the value max_val itself (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_line_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention the pointer
// port wins and the pointer moves to the other port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer only moves when both ports competed, so a lone grant does not steal priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= 1'b0;
    end else if (en && (&req)) begin
      ptr_reg <= ~ptr_reg;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Line-transfer controller: serves whole-line reads and writes for two cache ports over one
// single-port word memory, one transfer at a time, after a programmable access delay.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_LEN      = 11,
  parameter int LINE_ADDR_LEN = 3,
  parameter int WAIT_CYCLES   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rd_req0,
  input  logic                                      rd_req1,
  input  logic                                      wr_req0,
  input  logic                                      wr_req1,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]         line_addr0,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]         line_addr1,
  input  logic [WORD_W*(1<<LINE_ADDR_LEN)-1:0]      wr_line0,
  input  logic [WORD_W*(1<<LINE_ADDR_LEN)-1:0]      wr_line1,
  output logic                                      done0,
  output logic                                      done1,
  output logic [WORD_W*(1<<LINE_ADDR_LEN)-1:0]      rd_line,
  output logic [ADDR_LEN-1:0]                       mem_addr,
  output logic                                      mem_wr_req,
  output logic [WORD_W-1:0]                         mem_wr_data,
  input  logic [WORD_W-1:0]                         mem_rd_data
);

  localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);
  localparam int LINE_W    = WORD_W * LINE_SIZE;
  localparam int TAG_W     = ADDR_LEN - LINE_ADDR_LEN;
  localparam int CNT_W     = LINE_ADDR_LEN + 1;
  localparam int WAIT_W    = cnt_width(WAIT_CYCLES);

  localparam logic [CNT_W-1:0]         CNT_LAST_RD = CNT_W'(LINE_SIZE);
  localparam logic [CNT_W-1:0]         CNT_LAST_WR = CNT_W'(LINE_SIZE - 1);
  localparam logic [WAIT_W-1:0]        WAIT_LAST   = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD   = {LINE_ADDR_LEN{1'b1}};

  logic [2:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              port_reg;
  op_t               op_reg;
  op_t               op_sel;
  logic [TAG_W-1:0]  line_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [LINE_W-1:0] rd_line_reg;
  logic [1:0]        port_req;
  logic [1:0]        grant;
  logic [WORD_W-1:0] wdata_words [LINE_SIZE];

  assign port_req = {rd_req1 | wr_req1, rd_req0 | wr_req0};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state_reg == S_IDLE),
    .req   (port_req),
    .grant (grant)
  );

  // Within one port a pending write is served before a pending read.
  always_comb begin
    op_sel = OP_RD;
    if (grant[1] ? wr_req1 : wr_req0) begin
      op_sel = OP_WR;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (|grant) begin
          if (WAIT_CYCLES == 0) begin
            state_next = (op_sel == OP_WR) ? S_WRITE : S_READ;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_reg == WAIT_LAST) begin
          state_next = (op_reg == OP_WR) ? S_WRITE : S_READ;
        end
      end
      S_READ:  if (cnt_reg == CNT_LAST_RD) state_next = S_DONE;
      S_WRITE: if (cnt_reg == CNT_LAST_WR) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      wait_reg  <= '0;
      port_reg  <= 1'b0;
      op_reg    <= OP_RD;
      line_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          cnt_reg  <= '0;
          wait_reg <= '0;
          if (|grant) begin
            port_reg  <= grant[1];
            op_reg    <= op_sel;
            line_reg  <= grant[1] ? line_addr1 : line_addr0;
            wdata_reg <= grant[1] ? wr_line1 : wr_line0;
          end
        end
        S_WAIT:  wait_reg <= wait_reg + 1'b1;
        S_READ:  cnt_reg  <= cnt_reg + 1'b1;
        S_WRITE: cnt_reg  <= cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

  // Memory data lags the address by one cycle, so word k arrives while cnt == k+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_line_reg <= '0;
    end else if (state_reg == S_READ) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        if (cnt_reg == CNT_W'(i + 1)) begin
          rd_line_reg[WORD_W*i +: WORD_W] <= mem_rd_data;
        end
      end
    end
  end

  for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_wdata
    assign wdata_words[gi] = wdata_reg[WORD_W*gi +: WORD_W];
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_req  = 1'b0;
    mem_wr_data = '0;
    case (state_reg)
      S_READ: begin
        mem_addr = {line_reg, (cnt_reg == CNT_LAST_RD) ? LAST_WORD : cnt_reg[LINE_ADDR_LEN-1:0]};
      end
      S_WRITE: begin
        mem_wr_req  = 1'b1;
        mem_addr    = {line_reg, cnt_reg[LINE_ADDR_LEN-1:0]};
        mem_wr_data = wdata_words[cnt_reg[LINE_ADDR_LEN-1:0]];
      end
      default: ;
    endcase
  end

  assign done0   = (state_reg == S_DONE) && !port_reg;
  assign done1   = (state_reg == S_DONE) &&  port_reg;
  assign rd_line = rd_line_reg;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: word memory on the mem_* ports, a table of line transfers
// checked through an expectation queue, and hand sequences for contention and reset.
module tb_mem_line_arbiter;

  localparam int ADDR_LEN = 11;
  localparam int LAL      = 3;
  localparam int WAITC    = 4;
  localparam int LS       = 8;
  localparam int LW       = 32 * LS;
  localparam int TW       = ADDR_LEN - LAL;
  localparam int RD_LAT   = WAITC + LS + 2;
  localparam int WR_LAT   = WAITC + LS + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_req0 = 1'b0, rd_req1 = 1'b0, wr_req0 = 1'b0, wr_req1 = 1'b0;
  logic [TW-1:0] line_addr0 = '0, line_addr1 = '0;
  logic [LW-1:0] wr_line0 = '0, wr_line1 = '0;
  logic          done0, done1;
  logic [LW-1:0] rd_line;
  logic [ADDR_LEN-1:0] mem_addr;
  logic          mem_wr_req;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  always #5 clk = ~clk;

  mem_line_arbiter #(.ADDR_LEN(ADDR_LEN), .LINE_ADDR_LEN(LAL), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .rd_req0(rd_req0), .rd_req1(rd_req1), .wr_req0(wr_req0), .wr_req1(wr_req1),
    .line_addr0(line_addr0), .line_addr1(line_addr1),
    .wr_line0(wr_line0), .wr_line1(wr_line1),
    .done0(done0), .done1(done1), .rd_line(rd_line),
    .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Word memory with a bench-side preload port.
  logic [31:0]         mem [2048];
  logic                pl_en = 1'b0;
  logic [ADDR_LEN-1:0] pl_addr = '0;
  logic [31:0]         pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  logic [31:0] model [2048];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cycles = 0;
  int txn_id = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_wr_req) wr_cycles <= wr_cycles + 1;

  typedef struct {
    int            port;
    bit            is_rd;
    logic [LW-1:0] data;
    int            start;
    int            lat;
    int            id;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    int          port;
    bit          is_wr;
    int          line;
    logic [31:0] base;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [LW-1:0] model_line(input int line);
    logic [LW-1:0] d;
    for (int k = 0; k < LS; k++) d[32*k +: 32] = model[line*LS + k];
    return d;
  endfunction

  function automatic logic [LW-1:0] mem_line(input int line);
    logic [LW-1:0] d;
    for (int k = 0; k < LS; k++) d[32*k +: 32] = mem[line*LS + k];
    return d;
  endfunction

  // Scoreboard: every done pulse pops the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done0 || done1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done0=%b done1=%b required no pulse", done0, done1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("txn%0d_done_port", e.id), LW'({done1, done0}), LW'(e.port == 1 ? 2'b10 : 2'b01));
        check($sformatf("txn%0d_latency", e.id), LW'(cyc - e.start), LW'(e.lat));
        if (e.is_rd) check($sformatf("txn%0d_rd_line", e.id), rd_line, e.data);
        $display("[TB] txn %0d port %0d %s latency %0d", e.id, e.port, e.is_rd ? "read" : "write", cyc - e.start);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int port, input bit is_wr, input int line, input logic [31:0] base, input int lat);
    exp_t e;
    logic [LW-1:0] d;
    for (int k = 0; k < LS; k++) d[32*k +: 32] = base + 32'(k);
    if (port == 0) begin
      line_addr0 = TW'(line);
      if (is_wr) begin wr_line0 = d; wr_req0 = 1'b1; end else rd_req0 = 1'b1;
    end else begin
      line_addr1 = TW'(line);
      if (is_wr) begin wr_line1 = d; wr_req1 = 1'b1; end else rd_req1 = 1'b1;
    end
    if (is_wr) for (int k = 0; k < LS; k++) model[line*LS + k] = d[32*k +: 32];
    else d = model_line(line);
    e.port = port; e.is_rd = !is_wr; e.data = d; e.start = cyc; e.lat = lat; e.id = txn_id;
    txn_id++;
    exp_q.push_back(e);
  endtask

  // Acts as both requesters: drop the served request right after its done pulse.
  task automatic run(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (done0) begin if (wr_req0) wr_req0 = 1'b0; else rd_req0 = 1'b0; end
      if (done1) begin if (wr_req1) wr_req1 = 1'b0; else rd_req1 = 1'b0; end
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d transfers outstanding required 0", exp_q.size());
      exp_q.delete();
      rd_req0 = 1'b0; rd_req1 = 1'b0; wr_req0 = 1'b0; wr_req1 = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (3) sync();
    rst = 1'b1;
    sync();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] d;
    int w0, n;

    vecs[0] = '{0, 1'b0, 5,   32'h0,        RD_LAT};
    vecs[1] = '{1, 1'b1, 2,   32'h100,      WR_LAT};
    vecs[2] = '{1, 1'b0, 2,   32'h0,        RD_LAT};
    vecs[3] = '{0, 1'b1, 7,   32'hBEEF0000, WR_LAT};
    vecs[4] = '{0, 1'b0, 7,   32'h0,        RD_LAT};
    vecs[5] = '{1, 1'b1, 255, 32'hFFFFFFF8, WR_LAT};
    vecs[6] = '{0, 1'b0, 255, 32'h0,        RD_LAT};
    vecs[7] = '{1, 1'b0, 0,   32'h0,        RD_LAT};

    // Preload memory while the design is held in reset.
    rst = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      model[a] = (a >= 40 && a < 48) ? 32'hA0 + 32'(a - 40) : (32'(a) << 8) ^ 32'h5A5A0000;
      pl_en = 1'b1; pl_addr = ADDR_LEN'(a); pl_data = model[a];
      sync();
    end
    pl_en = 1'b0;
    sync();
    check("reset_done0", LW'(done0), LW'(0));
    check("reset_done1", LW'(done1), LW'(0));
    check("reset_mem_wr_req", LW'(mem_wr_req), LW'(0));
    check("reset_rd_line", rd_line, '0);
    check("reset_mem_addr", LW'(mem_addr), LW'(0));
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      sync();
      w0 = wr_cycles;
      issue(vecs[v].port, vecs[v].is_wr, vecs[v].line, vecs[v].base, vecs[v].lat);
      run(100);
      check($sformatf("vec%0d_wr_strobe_cycles", v), LW'(wr_cycles - w0), LW'(vecs[v].is_wr ? LS : 0));
      if (vecs[v].is_wr) check($sformatf("vec%0d_mem_line", v), mem_line(vecs[v].line), model_line(vecs[v].line));
    end

    // Contention straight after reset: port 0 first, then port 1 first on the repeat.
    pulse_reset();
    issue(0, 1'b0, 1, 32'h0, RD_LAT);
    issue(1, 1'b0, 6, 32'h0, RD_LAT + 1 + RD_LAT);
    run(100);
    sync();
    issue(1, 1'b0, 6, 32'h0, RD_LAT);
    issue(0, 1'b0, 1, 32'h0, RD_LAT + 1 + RD_LAT);
    run(100);

    // Same port asks for write and read together: write first, read returns the new data.
    sync();
    issue(0, 1'b1, 3, 32'h33000000, WR_LAT);
    issue(0, 1'b0, 3, 32'h0, WR_LAT + 1 + RD_LAT);
    run(100);

    // Inputs changed after grant must not affect the latched request.
    sync();
    issue(1, 1'b1, 9, 32'h900, WR_LAT);
    repeat (3) sync();
    line_addr1 = TW'(8'hEE);
    wr_line1 = '1;
    run(100);
    check("latched_write_line9", mem_line(9), model_line(9));
    check("latched_write_line238", mem_line(238), model_line(238));

    // Request dropped mid-transfer still completes with a done pulse.
    sync();
    issue(0, 1'b0, 9, 32'h0, RD_LAT);
    repeat (3) sync();
    rd_req0 = 1'b0;
    run(100);

    // Asynchronous reset while the fourth word of a write is on the bus.
    sync();
    for (int k = 0; k < LS; k++) d[32*k +: 32] = 32'hC0 + 32'(k);
    line_addr0 = TW'(4);
    wr_line0 = d;
    wr_req0 = 1'b1;
    n = 0;
    while (!(mem_wr_req && mem_addr == ADDR_LEN'(4*LS + 3)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_write_cnt3", LW'(n < 100), LW'(1));
    #1 rst = 1'b0;
    #1;
    check("async_rst_mem_wr_req", LW'(mem_wr_req), LW'(0));
    check("async_rst_done0", LW'(done0), LW'(0));
    check("async_rst_rd_line", rd_line, '0);
    check("async_rst_mem_addr", LW'(mem_addr), LW'(0));
    wr_req0 = 1'b0;
    repeat (2) sync();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model[4*LS + k] = d[32*k +: 32];
    check("partial_write_line4", mem_line(4), model_line(4));
    sync();
    issue(0, 1'b0, 4, 32'h0, RD_LAT);
    run(100);

    repeat (3) sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
